// File: rtl/subword_store_sequencer_pkg.sv
// rtl/subword_store_sequencer_pkg.sv - shared opcodes, sequencer state type and lane-width helper
package subword_store_sequencer_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Width of the byte-lane index within one memory word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/subword_store_sequencer_lane_merge.sv
// rtl/subword_store_sequencer_lane_merge.sv - replaces one little-endian byte or halfword lane of a word
module lane_merge
  import subword_store_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANE_W = lane_bits(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [15:0]       data,
  input  logic [LANE_W-1:0] lane,
  input  logic              is_half,
  output logic [DATA_W-1:0] merged
);

  // Halfword lanes ignore lane[0]; the caller rejects odd halfword addresses.
  always_comb begin
    merged = word;
    if (is_half) begin
      merged[{lane[LANE_W-1:1], 4'b0000} +: 16] = data;
    end else begin
      merged[{lane, 3'b000} +: 8] = data[7:0];
    end
  end

endmodule

// File: rtl/subword_store_sequencer.sv
// rtl/subword_store_sequencer.sv - read-modify-write sequencer for SB/SH stores, direct write for SW
module subword_store_sequencer
  import subword_store_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              instr_valid,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic              align_err
);

  localparam int LANE_W = lane_bits(DATA_W);

  state_t            state;
  state_t            state_next;
  logic [LANE_W-1:0] lane_q;
  logic              is_half_q;
  logic [15:0]       data_q;
  logic [DATA_W-1:0] merged;
  logic              misaligned;
  logic              accept_sub;
  logic              accept_sw;

  always_comb begin
    misaligned = instr_valid && (opcode == OP_SH) && addr[0];
    accept_sub = instr_valid && ((opcode == OP_SB) || (opcode == OP_SH)) && !misaligned;
    accept_sw  = instr_valid && (opcode == OP_SW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_sw) begin
          state_next = WRITE;
        end else if (accept_sub) begin
          state_next = READ;
        end
      end
      READ:    if (!mem_waitrequest) state_next = MERGE;
      MERGE:   state_next = WRITE;
      WRITE:   if (!mem_waitrequest) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // stall is released in the completing WRITE cycle so the pipeline restarts without a bubble.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    stall = accept_sub || accept_sw;
        WRITE:   stall = mem_waitrequest;
        default: stall = 1'b1;
      endcase
    end
  end

  lane_merge #(
    .DATA_W(DATA_W)
  ) u_lane_merge (
    .word    (mem_writedata),
    .data    (data_q),
    .lane    (lane_q),
    .is_half (is_half_q),
    .merged  (merged)
  );

  // Strobes are registered off the next state, so they drop with reset and never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      align_err     <= 1'b0;
      mem_addr      <= '0;
      mem_writedata <= '0;
      lane_q        <= '0;
      is_half_q     <= 1'b0;
      data_q        <= '0;
    end else if (clk_enable) begin
      mem_read  <= (state_next == READ);
      mem_write <= (state_next == WRITE);
      align_err <= (state == IDLE) && misaligned;
      case (state)
        IDLE: begin
          if (accept_sub || accept_sw) begin
            mem_addr      <= {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            lane_q        <= addr[LANE_W-1:0];
            is_half_q     <= (opcode == OP_SH);
            data_q        <= store_data[15:0];
            mem_writedata <= store_data;
          end
        end
        READ:    if (!mem_waitrequest) mem_writedata <= mem_readdata;
        MERGE:   mem_writedata <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subword_store_sequencer.sv
// tb/tb_subword_store_sequencer.sv - scoreboard bench for the subword store sequencer (32- and 64-bit)
module tb_subword_store_sequencer;
  import subword_store_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_enable;
  logic        instr_valid, stall, mem_read, mem_write, mem_waitrequest, align_err;
  logic [5:0]  opcode;
  logic [31:0] addr, store_data, mem_addr, mem_writedata, mem_readdata;

  logic        instr_valid64, stall64, mem_read64, mem_write64, align_err64;
  logic        mem_waitrequest64;
  logic [5:0]  opcode64;
  logic [31:0] addr64, mem_addr64;
  logic [63:0] store_data64, mem_writedata64, mem_readdata64;

  subword_store_sequencer #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr_valid(instr_valid),
    .opcode(opcode), .addr(addr), .store_data(store_data), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .align_err(align_err)
  );

  subword_store_sequencer #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr_valid(instr_valid64),
    .opcode(opcode64), .addr(addr64), .store_data(store_data64), .stall(stall64),
    .mem_read(mem_read64), .mem_write(mem_write64), .mem_addr(mem_addr64),
    .mem_writedata(mem_writedata64), .mem_readdata(mem_readdata64),
    .mem_waitrequest(mem_waitrequest64), .align_err(align_err64)
  );

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp64_q[$];
  int  errors = 0;
  int  checks = 0;
  int  stall_cnt, read_cnt, aerr_cnt, wcyc_cnt, stall64_cnt;
  int  wait_n = 0;
  int  wcnt = 0;
  bit  hold_wait = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder for the 32-bit instance: wait_n wait states per strobe.
  initial begin
    mem_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_wait) begin
        mem_waitrequest = 1'b1;
      end else if (mem_read || mem_write) begin
        if (wcnt < wait_n) begin
          mem_waitrequest = 1'b1;
          wcnt++;
        end else begin
          mem_waitrequest = 1'b0;
          wcnt = 0;
        end
      end else begin
        mem_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        stall_cnt   += int'(stall);
        stall64_cnt += int'(stall64);
        aerr_cnt    += int'(align_err);
        wcyc_cnt    += int'(mem_write);
        if (mem_read && !mem_waitrequest) read_cnt++;
        if (mem_read || mem_write) check("strobe_exclusive", {63'd0, mem_read && mem_write}, 64'd0);
        if (mem_write && !mem_waitrequest) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_writedata);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {32'd0, mem_addr}, {32'd0, e.a});
            check("wr_data", {32'd0, mem_writedata}, e.d);
          end
        end
        if (mem_write64) begin
          if (exp64_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write64: addr %h data %h, none expected", mem_addr64, mem_writedata64);
          end else begin
            e = exp64_q.pop_front();
            check("wr64_addr", {32'd0, mem_addr64}, {32'd0, e.a});
            check("wr64_data", mem_writedata64, e.d);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #3;
      if (!stall && !mem_read && !mem_write && !stall64 && !mem_read64 && !mem_write64) done = 1'b1;
      else @(negedge clk);
    end
    check("idle_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int wn, input bit exp_wr,
                       input logic [31:0] exp_a, input logic [31:0] exp_d,
                       input int exp_stall, input int exp_reads, input int exp_aerr);
    @(negedge clk);
    mem_readdata = rd;
    wait_n = wn;
    stall_cnt = 0; read_cnt = 0; aerr_cnt = 0; wcyc_cnt = 0;
    if (exp_wr) exp_q.push_back('{exp_a, {32'd0, exp_d}});
    opcode = op; addr = a; store_data = d; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = 6'd0;
    wait_idle();
    repeat (2) @(negedge clk);
    #3;
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    check("read_count", 64'(read_cnt), 64'(exp_reads));
    check("align_err_pulses", 64'(aerr_cnt), 64'(exp_aerr));
    check("write_cycles", 64'(wcyc_cnt), exp_wr ? 64'(wn + 1) : 64'd0);
    check("write_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic issue64(input logic [5:0] op, input logic [31:0] a, input logic [63:0] d,
                         input logic [63:0] rd, input logic [31:0] exp_a, input logic [63:0] exp_d,
                         input int exp_stall);
    @(negedge clk);
    mem_readdata64 = rd;
    stall64_cnt = 0;
    exp64_q.push_back('{exp_a, exp_d});
    opcode64 = op; addr64 = a; store_data64 = d; instr_valid64 = 1'b1;
    @(negedge clk);
    instr_valid64 = 1'b0;
    opcode64 = 6'd0;
    wait_idle();
    repeat (2) @(negedge clk);
    #3;
    check("stall64_cycles", 64'(stall64_cnt), 64'(exp_stall));
    check("write64_done", 64'(exp64_q.size()), 64'd0);
    exp64_q.delete();
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1;
    instr_valid = 1'b0; opcode = 6'd0; addr = '0; store_data = '0; mem_readdata = '0;
    instr_valid64 = 1'b0; opcode64 = 6'd0; addr64 = '0; store_data64 = '0;
    mem_readdata64 = '0; mem_waitrequest64 = 1'b0;
    stall_cnt = 0; read_cnt = 0; aerr_cnt = 0; wcyc_cnt = 0; stall64_cnt = 0;
    #2;
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_mem_write", {63'd0, mem_write}, 64'd0);
    check("rst_align_err", {63'd0, align_err}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_mem_writedata", {32'd0, mem_writedata}, 64'd0);
    check("rst_mem_writedata64", mem_writedata64, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(OP_SB, 32'h1000_0002, 32'h0000_00AB, 32'h1122_3344, 0, 1, 32'h1000_0000, 32'h11AB_3344, 3, 1, 0);
    issue(OP_SH, 32'h1000_0002, 32'h0000_BEEF, 32'h1122_3344, 2, 1, 32'h1000_0000, 32'hBEEF_3344, 7, 1, 0);
    issue(OP_SH, 32'h1000_0003, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    issue(OP_SW, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 0, 1, 32'h0000_0020, 32'hDEAD_BEEF, 1, 0, 0);
    issue(OP_SB, 32'h1000_0001, 32'h0000_0055, 32'hFFFF_FFFF, 1, 1, 32'h1000_0000, 32'hFFFF_55FF, 5, 1, 0);
    issue(OP_SH, 32'h0000_0000, 32'h0000_1234, 32'hAABB_CCDD, 0, 1, 32'h0000_0000, 32'hAABB_1234, 3, 1, 0);
    issue(OP_SB, 32'h0000_0103, 32'h1234_5677, 32'h0000_0000, 0, 1, 32'h0000_0100, 32'h7700_0000, 3, 1, 0);
    issue(6'b100011, 32'h0000_0040, 32'h1111_1111, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    issue(OP_SW, 32'h0000_0023, 32'hCAFE_F00D, 32'h0, 1, 1, 32'h0000_0020, 32'hCAFE_F00D, 2, 0, 0);

    // clk_enable low: a presented SW stalls but nothing advances
    @(negedge clk);
    stall_cnt = 0; read_cnt = 0; wcyc_cnt = 0;
    clk_enable = 1'b0;
    opcode = OP_SW; addr = 32'h0000_0060; store_data = 32'h5A5A_5A5A; instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    opcode = 6'd0;
    clk_enable = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("freeze_stall_cycles", 64'(stall_cnt), 64'd3);
    check("freeze_write_cycles", 64'(wcyc_cnt), 64'd0);

    // reset during a write held off by waitrequest
    hold_wait = 1'b1;
    @(negedge clk);
    opcode = OP_SW; addr = 32'h0000_0080; store_data = 32'h1234_5678; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = 6'd0;
    #3;
    check("mid_write_strobe", {63'd0, mem_write}, 64'd1);
    reset = 1'b1;
    #1;
    check("rst_async_mem_write", {63'd0, mem_write}, 64'd0);
    check("rst_async_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_async_stall", {63'd0, stall}, 64'd0);
    check("rst_async_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_async_writedata", {32'd0, mem_writedata}, 64'd0);
    repeat (2) @(negedge clk);
    hold_wait = 1'b0;
    reset = 1'b0;
    issue(OP_SW, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 0, 1, 32'h0000_0040, 32'h0BAD_F00D, 1, 0, 0);

    issue64(OP_SB, 32'h0000_0007, 64'h0000_0000_0000_00CD, 64'h0, 32'h0000_0000, 64'hCD00_0000_0000_0000, 3);
    issue64(OP_SH, 32'h0000_0016, 64'h0000_0000_0000_BEEF, 64'h1111_1111_1111_1111,
            32'h0000_0010, 64'hBEEF_1111_1111_1111, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subword_store_sequencer.md
SUBWORD_STORE_SEQUENCER -- requirements
Module: subword_store_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits; multiple of 16, at least 32.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: clk_enable  input  1  when low, all registers hold their value.
REQ-007 Port: instr_valid  input  1  the opcode, addr and store_data fields are valid this cycle.
REQ-008 Port: opcode  input  6  SB=101000, SH=101001, SW=101011; any other value is ignored.
REQ-009 Port: addr  input  ADDR_W  effective byte address.
REQ-010 Port: store_data  input  DATA_W  source register value; the byte or halfword is taken from the low bits.
REQ-011 Port: stall  output  1  hold PC and the delay-slot register.
REQ-012 Port: mem_read, mem_write  output  1 each  memory strobes.
REQ-013 Port: mem_addr  output  ADDR_W  word-aligned address, low log2(DATA_W/8) bits zero.
REQ-014 Port: mem_writedata  output  DATA_W  write data.
REQ-015 Port: mem_readdata  input  DATA_W  read data, valid when mem_read=1 and mem_waitrequest=0.
REQ-016 Port: mem_waitrequest  input  1  memory not ready; the current strobe must be held.
REQ-017 Port: align_err  output  1  one-cycle pulse when an SH address is misaligned.

Function
REQ-018 SHALL implement the states IDLE, READ, MERGE, WRITE.
REQ-019 IDLE: when instr_valid is high and opcode is SB or SH, SHALL latch the aligned address, the lane index (addr low bits) and store_data, then go to READ.
REQ-020 IDLE: when instr_valid is high and opcode is SW, SHALL go directly to WRITE with mem_writedata = store_data; there is no read.
REQ-021 READ: SHALL hold mem_read high until mem_waitrequest is low, capture mem_readdata on that edge, then go to MERGE.
REQ-022 MERGE: SHALL last one cycle; SHALL replace only the addressed lane (little-endian: byte k = bits 8k+7:8k; halfword h = bits 16h+15:16h) and keep every other bit of the read word.
REQ-023 WRITE: SHALL hold mem_write high with stable mem_addr and mem_writedata until mem_waitrequest is low, then go to IDLE.
REQ-024 SH with addr[0]=1: SHALL pulse align_err for one cycle, issue no memory access, leave stall low, and remain in IDLE.
REQ-025 stall SHALL be combinational: high in the accepting IDLE cycle and in every non-IDLE cycle except the final WRITE cycle in which mem_waitrequest is low.
REQ-026 With zero wait states: SB or SH SHALL take 3 cycles (READ, MERGE, WRITE); SW SHALL take 1 cycle.
REQ-027 mem_read and mem_write SHALL never both be high; both SHALL come directly from registered state.
REQ-028 Inputs SHALL be ignored outside IDLE; a new instruction is accepted in the cycle after the return to IDLE.
REQ-029 clk_enable low SHALL freeze state, latched data and strobe levels.

Reset
REQ-030 While reset is high, independent of clk: state=IDLE; mem_read, mem_write, align_err and stall = 0; mem_addr, mem_writedata and latched data = 0.
REQ-031 Reset asserted mid-operation SHALL drop the strobes immediately and abandon the access without a partial write.

Structure
REQ-032 A shared package SHALL hold the opcode constants (OP_SB, OP_SH, OP_SW) and the state enum type.
REQ-033 Lane merging SHALL be a sub-module, lane_merge, parametrised by DATA_W: inputs word, data, lane, is_half; output merged word.

Verification
REQ-034 SB, addr=0x10000002, store_data=0x000000AB, readdata=0x11223344, no wait -> write 0x11AB3344 to 0x10000000; stall high for 3 cycles.
REQ-035 SH, addr=0x10000002, store_data=0x0000BEEF, readdata=0x11223344, 2 wait cycles on both the read and the write -> write 0xBEEF3344; stall high for 7 cycles.
REQ-036 SH, addr=0x10000003 -> align_err pulses once; no strobe; stall stays 0.
REQ-037 SW, addr=0x20, store_data=0xDEADBEEF -> one write cycle with mem_addr=0x20 and data 0xDEADBEEF; no read.
REQ-038 reset asserted during WRITE with mem_waitrequest held high -> mem_write=0 before the next clock edge; state IDLE.
REQ-039 DATA_W=64, SB, addr=0x7, readdata=0 -> write 0xCD00000000000000 for store_data=0xCD.
